// File: rtl/cpu.sv
// rtl/cpu.sv - multicycle 64-bit Tinker integer core with internal byte memory (optional MULDIV_EN enables mul/div)

// Unified little-endian byte memory: combinational reads, synchronous 8-byte writes.
module cpu_memory #(
    parameter int MEM_SIZE = 524288
) (
    input  logic        clk,
    input  logic [63:0] i_iaddr,
    output logic [31:0] o_idata,
    input  logic [63:0] i_daddr,
    output logic [63:0] o_ddata,
    input  logic        i_we,
    input  logic [63:0] i_wdata
);
    localparam int AW = $clog2(MEM_SIZE);

    logic [7:0] bytes [0:MEM_SIZE-1];

    // Byte address k bytes past a, wrapped into the memory so straddling accesses wrap to 0.
    function automatic logic [AW-1:0] wrap(input logic [63:0] a, input int k);
        return AW'((a + 64'(k)) % 64'(MEM_SIZE));
    endfunction

    // Instruction and data read ports, assembled little-endian.
    always_comb begin
        o_idata = '0;
        o_ddata = '0;
        for (int k = 0; k < 4; k++) o_idata[8*k +: 8] = bytes[wrap(i_iaddr, k)];
        for (int k = 0; k < 8; k++) o_ddata[8*k +: 8] = bytes[wrap(i_daddr, k)];
    end

    // Data write port; contents intentionally survive reset so programs can be preloaded.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < 8; k++) bytes[wrap(i_daddr, k)] <= i_wdata[8*k +: 8];
        end
    end
endmodule

module cpu #(
    parameter int          MEM_SIZE = 524288,
    parameter logic [31:0] START_PC = 32'h2000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        halt,
    input  logic        in_signal,
    input  logic [63:0] in_data,
    output logic        out_signal,
    output logic [63:0] out_data
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALTED} state_t;

    state_t      r_state, w_next_state;
    logic [63:0] r_pc;
    logic [31:0] r_ir;
    logic [63:0] r_regs [0:31];
    logic        r_out_signal;
    logic [63:0] r_out_data;

    logic [4:0]  w_op, w_rd, w_rs, w_rt;
    logic [11:0] w_l;
    logic [63:0] w_lz, w_ls, w_vd, w_vs, w_vt;
    logic [31:0] w_idata;
    logic [63:0] w_mem_rdata, w_daddr, w_wdata, w_pc_next, w_reg_val;
    logic        w_ir_we, w_pc_we, w_reg_we, w_mem_we, w_out_we;

    assign w_op = r_ir[31:27];
    assign w_rd = r_ir[26:22];
    assign w_rs = r_ir[21:17];
    assign w_rt = r_ir[16:12];
    assign w_l  = r_ir[11:0];
    assign w_lz = {52'd0, w_l};
    assign w_ls = {{52{w_l[11]}}, w_l};
    assign w_vd = r_regs[w_rd];
    assign w_vs = r_regs[w_rs];
    assign w_vt = r_regs[w_rt];

    assign halt       = (r_state == S_HALTED);
    assign out_signal = r_out_signal;
    assign out_data   = r_out_data;

    cpu_memory #(.MEM_SIZE(MEM_SIZE)) memory (
        .clk     (clk),
        .i_iaddr (r_pc),
        .o_idata (w_idata),
        .i_daddr (w_daddr),
        .o_ddata (w_mem_rdata),
        .i_we    (w_mem_we),
        .i_wdata (w_wdata)
    );

    // Next state and per-instruction effects; anything that halts suppresses every write.
    always_comb begin
        w_next_state = r_state;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_next    = r_pc + 64'd4;
        w_reg_we     = 1'b0;
        w_reg_val    = w_vd;
        w_mem_we     = 1'b0;
        w_daddr      = w_vs + w_ls;
        w_wdata      = w_vs;
        w_out_we     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_we      = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_next_state = S_FETCH;
                w_pc_we      = 1'b1;
                case (w_op)
                    5'h00: begin w_reg_we = 1'b1; w_reg_val = w_vs & w_vt; end
                    5'h01: begin w_reg_we = 1'b1; w_reg_val = w_vs | w_vt; end
                    5'h02: begin w_reg_we = 1'b1; w_reg_val = w_vs ^ w_vt; end
                    5'h03: begin w_reg_we = 1'b1; w_reg_val = ~w_vs; end
                    5'h04: begin w_reg_we = 1'b1; w_reg_val = w_vs >> w_vt[5:0]; end
                    5'h05: begin w_reg_we = 1'b1; w_reg_val = w_vd >> w_lz; end
                    5'h06: begin w_reg_we = 1'b1; w_reg_val = w_vs << w_vt[5:0]; end
                    5'h07: begin w_reg_we = 1'b1; w_reg_val = w_vd << w_lz; end
                    5'h08: w_pc_next = w_vd;
                    5'h09: w_pc_next = r_pc + w_vd;
                    5'h0a: w_pc_next = r_pc + w_ls;
                    5'h0b: if (w_vs != 64'd0) w_pc_next = w_vd;
                    5'h0c: begin
                        w_mem_we  = 1'b1;
                        w_daddr   = r_regs[31] - 64'd8;
                        w_wdata   = r_pc + 64'd4;
                        w_pc_next = w_vd;
                    end
                    5'h0d: begin
                        w_daddr   = r_regs[31] - 64'd8;
                        w_pc_next = w_mem_rdata;
                    end
                    5'h0e: if ($signed(w_vs) > $signed(w_vt)) w_pc_next = w_vd;
                    5'h0f: begin
                        case (w_l)
                            12'd3: begin
                                if (in_signal) begin
                                    w_reg_we  = 1'b1;
                                    w_reg_val = in_data;
                                end else begin
                                    w_next_state = S_EXEC;
                                    w_pc_we      = 1'b0;
                                end
                            end
                            12'd4: w_out_we = 1'b1;
                            default: begin
                                w_next_state = S_HALTED;
                                w_pc_we      = 1'b0;
                            end
                        endcase
                    end
                    5'h10: begin w_reg_we = 1'b1; w_reg_val = w_mem_rdata; end
                    5'h11: begin w_reg_we = 1'b1; w_reg_val = w_vs; end
                    5'h12: begin w_reg_we = 1'b1; w_reg_val = {w_vd[63:12], w_l}; end
                    5'h13: begin
                        w_mem_we = 1'b1;
                        w_daddr  = w_vd + w_ls;
                    end
                    5'h18: begin w_reg_we = 1'b1; w_reg_val = w_vs + w_vt; end
                    5'h19: begin w_reg_we = 1'b1; w_reg_val = w_vd + w_lz; end
                    5'h1a: begin w_reg_we = 1'b1; w_reg_val = w_vs - w_vt; end
                    5'h1b: begin w_reg_we = 1'b1; w_reg_val = w_vd - w_lz; end
`ifdef MULDIV_EN
                    5'h1c: begin w_reg_we = 1'b1; w_reg_val = w_vs * w_vt; end
                    5'h1d: begin
                        w_reg_we  = 1'b1;
                        w_reg_val = (w_vt == 64'd0) ? 64'd0 : 64'($signed(w_vs) / $signed(w_vt));
                    end
`endif
                    default: begin
                        w_next_state = S_HALTED;
                        w_pc_we      = 1'b0;
                    end
                endcase
            end
            default: w_next_state = S_HALTED;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    // Architectural state: PC, IR, register file and the output port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= 64'(START_PC);
            r_ir         <= '0;
            r_out_signal <= 1'b0;
            r_out_data   <= '0;
            for (int i = 0; i < 31; i++) r_regs[i] <= '0;
            r_regs[31]   <= 64'(MEM_SIZE);
        end else begin
            r_out_signal <= w_out_we;
            if (w_out_we) r_out_data <= w_vs;
            if (w_ir_we)  r_ir <= w_idata;
            if (w_pc_we)  r_pc <= w_pc_next;
            if (w_reg_we) r_regs[w_rd] <= w_reg_val;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for cpu
module tb_cpu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        halt;
    logic        in_signal = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_signal;
    logic [63:0] out_data;

    int errors = 0;
    int checks = 0;

    cpu dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .in_signal  (in_signal),
        .in_data    (in_data),
        .out_signal (out_signal),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [11:0] l);
        return {op, rd, rs, rt, l};
    endfunction

    task automatic put32(input int addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.memory.bytes[addr + k] = w[8*k +: 8];
    endtask

    function automatic logic [63:0] mem64(input int addr);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = dut.memory.bytes[addr + k];
        return v;
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        in_signal = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input int budget, output int pulses, output logic [63:0] last);
        int n;
        pulses = 0;
        last = '0;
        n = 0;
        while (!halt && n < budget) begin
            @(negedge clk);
            if (out_signal) begin pulses++; last = out_data; end
            n++;
        end
        checks++;
        if (!halt) begin
            errors++;
            $display("FAIL run_timeout: halt=%0b after %0d cycles, required 1", halt, n);
        end
    endtask

    task automatic test_reset();
        int bad;
        int pulses;
        hold_reset();
        put32(32'h2000, 32'h7800_0000);
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %0b want 0", halt); end
        checks++; if (out_signal !== 1'b0) begin errors++; $display("FAIL reset_out_signal: got %0b want 0", out_signal); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        release_reset();
        pulses = 0;
        repeat (2) begin @(negedge clk); if (out_signal) pulses++; end
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_latency: got %0b want 1", halt); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL halt_no_out: got %0d pulses want 0", pulses); end
        bad = 0;
        for (int i = 0; i < 31; i++) if (dut.r_regs[i] !== 64'd0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_regs: %0d nonzero r0-r30, want 0", bad); end
        checks++; if (dut.r_regs[31] !== 64'd524288) begin errors++; $display("FAIL reset_sp: got %0d want 524288", dut.r_regs[31]); end
        checks++; if (dut.r_pc !== 64'h2000) begin errors++; $display("FAIL halt_pc: got %h want 2000", dut.r_pc); end
    endtask

    task automatic test_output();
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd5));
        put32(32'h2004, enc(5'h19, 5'd1, 5'd0, 5'd0, 12'd7));
        put32(32'h2008, enc(5'h0f, 5'd0, 5'd1, 5'd0, 12'd4));
        put32(32'h200c, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        run(100, pulses, last);
        checks++; if (pulses != 1) begin errors++; $display("FAIL out_pulses: got %0d want 1", pulses); end
        checks++; if (last !== 64'hC) begin errors++; $display("FAIL out_value: got %h want c", last); end
        checks++; if (out_data !== 64'hC) begin errors++; $display("FAIL out_hold: got %h want c", out_data); end
    endtask

    task automatic test_input_wait();
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h0f, 5'd2, 5'd0, 5'd0, 12'd3));
        put32(32'h2004, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        repeat (10) @(negedge clk);
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL wait_halt: got %0b want 0", halt); end
        checks++; if (dut.r_pc !== 64'h2000) begin errors++; $display("FAIL wait_pc: got %h want 2000", dut.r_pc); end
        checks++; if (dut.r_regs[2] !== 64'd0) begin errors++; $display("FAIL wait_reg: got %h want 0", dut.r_regs[2]); end
        in_signal = 1'b1;
        in_data = 64'hDEADBEEF;
        @(negedge clk);
        in_signal = 1'b0;
        in_data = '0;
        checks++; if (dut.r_pc !== 64'h2004) begin errors++; $display("FAIL input_pc: got %h want 2004", dut.r_pc); end
        checks++; if (dut.r_regs[2] !== 64'hDEADBEEF) begin errors++; $display("FAIL input_reg: got %h want deadbeef", dut.r_regs[2]); end
        run(20, pulses, last);
    endtask

    task automatic test_call_return();
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h12, 5'd5, 5'd0, 5'd0, 12'h100));
        put32(32'h2004, enc(5'h0c, 5'd5, 5'd0, 5'd0, 12'd0));
        put32(32'h2008, enc(5'h0f, 5'd0, 5'd6, 5'd0, 12'd4));
        put32(32'h200c, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        put32(32'h0100, enc(5'h12, 5'd6, 5'd0, 5'd0, 12'h055));
        put32(32'h0104, enc(5'h0d, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        run(100, pulses, last);
        checks++; if (pulses != 1 || last !== 64'h55) begin errors++; $display("FAIL call_return_out: got %0d pulses value %h want 1 pulse value 55", pulses, last); end
        checks++; if (mem64(32'h7FFF8) !== 64'h2008) begin errors++; $display("FAIL call_saved_ra: got %h want 2008", mem64(32'h7FFF8)); end
        checks++; if (dut.r_pc !== 64'h200C) begin errors++; $display("FAIL call_final_pc: got %h want 200c", dut.r_pc); end
    endtask

    task automatic test_brgt(input bit taken);
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd1));
        if (taken) put32(32'h2004, enc(5'h12, 5'd2, 5'd0, 5'd0, 12'd2));
        else       put32(32'h2004, enc(5'h1b, 5'd2, 5'd0, 5'd0, 12'd1));
        put32(32'h2008, enc(5'h12, 5'd3, 5'd0, 5'd0, 12'h200));
        put32(32'h200c, enc(5'h0e, 5'd3, 5'd2, 5'd1, 12'd0));
        put32(32'h2010, enc(5'h12, 5'd4, 5'd0, 5'd0, 12'h0AA));
        put32(32'h2014, enc(5'h0f, 5'd0, 5'd4, 5'd0, 12'd4));
        put32(32'h2018, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        put32(32'h0200, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        run(100, pulses, last);
        if (taken) begin
            checks++; if (pulses != 0) begin errors++; $display("FAIL brgt_taken_out: got %0d pulses want 0", pulses); end
            checks++; if (dut.r_pc !== 64'h200) begin errors++; $display("FAIL brgt_taken_pc: got %h want 200", dut.r_pc); end
        end else begin
            checks++; if (pulses != 1 || last !== 64'hAA) begin errors++; $display("FAIL brgt_fall_out: got %0d pulses value %h want 1 pulse value aa", pulses, last); end
            checks++; if (dut.r_pc !== 64'h2018) begin errors++; $display("FAIL brgt_fall_pc: got %h want 2018", dut.r_pc); end
        end
    endtask

    task automatic test_alu();
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h12, 5'd1, 5'd0, 5'd0, 12'h0F0));
        put32(32'h2004, enc(5'h12, 5'd2, 5'd0, 5'd0, 12'h03C));
        put32(32'h2008, enc(5'h12, 5'd8, 5'd0, 5'd0, 12'd4));
        put32(32'h200c, enc(5'h00, 5'd3, 5'd1, 5'd2, 12'd0));
        put32(32'h2010, enc(5'h01, 5'd4, 5'd1, 5'd2, 12'd0));
        put32(32'h2014, enc(5'h02, 5'd5, 5'd1, 5'd2, 12'd0));
        put32(32'h2018, enc(5'h03, 5'd6, 5'd1, 5'd0, 12'd0));
        put32(32'h201c, enc(5'h04, 5'd7, 5'd1, 5'd8, 12'd0));
        put32(32'h2020, enc(5'h1a, 5'd9, 5'd2, 5'd1, 12'd0));
        put32(32'h2024, enc(5'h18, 5'd10, 5'd1, 5'd2, 12'd0));
        put32(32'h2028, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        run(100, pulses, last);
        checks++; if (dut.r_regs[3] !== 64'h30) begin errors++; $display("FAIL alu_and: got %h want 30", dut.r_regs[3]); end
        checks++; if (dut.r_regs[4] !== 64'hFC) begin errors++; $display("FAIL alu_or: got %h want fc", dut.r_regs[4]); end
        checks++; if (dut.r_regs[5] !== 64'hCC) begin errors++; $display("FAIL alu_xor: got %h want cc", dut.r_regs[5]); end
        checks++; if (dut.r_regs[6] !== 64'hFFFF_FFFF_FFFF_FF0F) begin errors++; $display("FAIL alu_not: got %h want ffffffffffffff0f", dut.r_regs[6]); end
        checks++; if (dut.r_regs[7] !== 64'hF) begin errors++; $display("FAIL alu_shftr: got %h want f", dut.r_regs[7]); end
        checks++; if (dut.r_regs[9] !== 64'hFFFF_FFFF_FFFF_FF4C) begin errors++; $display("FAIL alu_sub: got %h want ffffffffffffff4c", dut.r_regs[9]); end
        checks++; if (dut.r_regs[10] !== 64'h12C) begin errors++; $display("FAIL alu_add: got %h want 12c", dut.r_regs[10]); end
    endtask

    task automatic test_wrap();
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h11, 5'd1, 5'd31, 5'd0, 12'd0));
        put32(32'h2004, enc(5'h1b, 5'd1, 5'd0, 5'd0, 12'd4));
        put32(32'h2008, enc(5'h12, 5'd2, 5'd0, 5'd0, 12'hABC));
        put32(32'h200c, enc(5'h07, 5'd2, 5'd0, 5'd0, 12'd52));
        put32(32'h2010, enc(5'h19, 5'd2, 5'd0, 5'd0, 12'h123));
        put32(32'h2014, enc(5'h13, 5'd1, 5'd2, 5'd0, 12'd0));
        put32(32'h2018, enc(5'h10, 5'd3, 5'd1, 5'd0, 12'd0));
        put32(32'h201c, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        run(100, pulses, last);
        checks++; if (dut.r_regs[3] !== 64'hABC0_0000_0000_0123) begin errors++; $display("FAIL wrap_load: got %h want abc0000000000123", dut.r_regs[3]); end
        checks++; if (dut.memory.bytes[3] !== 8'hAB) begin errors++; $display("FAIL wrap_low_byte: got %h want ab", dut.memory.bytes[3]); end
        checks++; if (dut.memory.bytes[32'h7FFFC] !== 8'h23) begin errors++; $display("FAIL wrap_top_byte: got %h want 23", dut.memory.bytes[32'h7FFFC]); end
    endtask

    task automatic test_illegal();
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd3));
        put32(32'h2004, enc(5'h14, 5'd1, 5'd1, 5'd1, 12'd0));
        put32(32'h2008, enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd7));
        put32(32'h200c, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        run(100, pulses, last);
        checks++; if (dut.r_pc !== 64'h2004) begin errors++; $display("FAIL illegal_pc: got %h want 2004", dut.r_pc); end
        checks++; if (dut.r_regs[1] !== 64'd3) begin errors++; $display("FAIL illegal_reg: got %h want 3", dut.r_regs[1]); end
    endtask

    task automatic test_div_zero();
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd7));
        put32(32'h2004, enc(5'h12, 5'd3, 5'd0, 5'd0, 12'h033));
        put32(32'h2008, enc(5'h1d, 5'd3, 5'd1, 5'd2, 12'd0));
        put32(32'h200c, enc(5'h12, 5'd4, 5'd0, 5'd0, 12'd9));
        put32(32'h2010, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        run(100, pulses, last);
`ifdef MULDIV_EN
        checks++; if (dut.r_regs[3] !== 64'd0) begin errors++; $display("FAIL div0_rd: got %h want 0", dut.r_regs[3]); end
        checks++; if (dut.r_regs[4] !== 64'd9 || dut.r_pc !== 64'h2010) begin errors++; $display("FAIL div0_continue: r4=%h pc=%h want 9 2010", dut.r_regs[4], dut.r_pc); end
`else
        checks++; if (dut.r_regs[3] !== 64'h33) begin errors++; $display("FAIL div0_rd: got %h want 33", dut.r_regs[3]); end
        checks++; if (dut.r_regs[4] !== 64'd0 || dut.r_pc !== 64'h2008) begin errors++; $display("FAIL div0_halt: r4=%h pc=%h want 0 2008", dut.r_regs[4], dut.r_pc); end
`endif
    endtask

`ifdef MULDIV_EN
    task automatic test_muldiv();
        int pulses;
        logic [63:0] last;
        hold_reset();
        put32(32'h2000, enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd7));
        put32(32'h2004, enc(5'h1b, 5'd2, 5'd0, 5'd0, 12'd2));
        put32(32'h2008, enc(5'h1d, 5'd5, 5'd1, 5'd2, 12'd0));
        put32(32'h200c, enc(5'h1c, 5'd6, 5'd1, 5'd2, 12'd0));
        put32(32'h2010, enc(5'h0f, 5'd0, 5'd0, 5'd0, 12'd0));
        release_reset();
        run(100, pulses, last);
        checks++; if (dut.r_regs[5] !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_signed: got %h want fffffffffffffffd", dut.r_regs[5]); end
        checks++; if (dut.r_regs[6] !== 64'hFFFF_FFFF_FFFF_FFF2) begin errors++; $display("FAIL mul_signed: got %h want fffffffffffffff2", dut.r_regs[6]); end
    endtask
`endif

    initial begin
        test_reset();
        test_output();
        test_input_wait();
        test_call_return();
        test_brgt(1'b0);
        test_brgt(1'b1);
        test_alu();
        test_wrap();
        test_illegal();
        test_div_zero();
`ifdef MULDIV_EN
        test_muldiv();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Multicycle 64-bit processor implementing the integer subset of the Tinker ISA, with its own internal unified byte-addressed memory.
- Programs are preloaded into the memory instance `memory` (byte array `bytes`) by hierarchical access while reset is asserted.
- The core fetches and executes programs from that memory and exchanges data with the environment through one input port and one output port.
- It raises `halt` when the program finishes or faults.

Parameters:
- MEM_SIZE, 524288: memory size in bytes. Addresses wrap modulo MEM_SIZE.
- START_PC, 32'h2000: PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- halt  output  1  sticky; high once the core stops.
- in_signal  input  1  input-data-valid qualifier.
- in_data  input  64  input data word.
- out_signal  output  1  one-cycle strobe marking out_data valid.
- out_data  output  64  output data word; holds its value between strobes.

Behaviour:
- Reset (reset=0, asynchronous) sets the following; the memory contents are NOT cleared.
  - PC=START_PC.
  - r0–r30 = 0; r31 = MEM_SIZE (stack pointer).
  - halt=0, out_signal=0, out_data=0.
  - FSM state = FETCH.
- State register: 32 x 64-bit general registers. r0 is an ordinary writable register.
- Memory reads are combinational: 4 bytes for an instruction, 8 bytes for data, little-endian. Memory writes are synchronous, 8 bytes, little-endian.
- Instruction format (32-bit): op[31:27], rd[26:22], rs[21:17], rt[16:12], L[11:0].
- L extension: zero-extended for addi/subi/shftri/shftli/mov 0x12; sign-extended for memory offsets and brr L.
- FSM states:
  - FETCH: IR <= mem32[PC]; go to EXEC.
  - EXEC: execute IR; go to FETCH. Exception: priv input waiting, which stays in EXEC.
  - HALTED: absorbing until reset.
- Instruction latency: 2 cycles per instruction, excluding input waits.
- Default next PC is PC+4.
- Opcodes:
  - 0x0 and, 0x1 or, 0x2 xor, 0x3 not (rd = ~rs).
  - 0x4 shftr rd = rs >> rt[5:0] (logical); 0x5 shftri rd = rd >> L.
  - 0x6 shftl rd = rs << rt[5:0]; 0x7 shftli rd = rd << L.
  - 0x8 br: PC = rd.
  - 0x9 brr: PC = PC + rd.
  - 0xa brr L: PC = PC + sext(L).
  - 0xb brnz: if rs != 0 then PC = rd.
  - 0xc call: mem64[r31-8] = PC+4; PC = rd.
  - 0xd return: PC = mem64[r31-8].
  - 0xe brgt: if signed rs > rt then PC = rd.
  - 0xf priv:
    - L=0: halt.
    - L=3: wait in EXEC until in_signal=1, then rd = in_data.
    - L=4: out_data = rs and out_signal=1 for exactly one cycle.
    - Any other L: illegal.
  - 0x10 mov: rd = mem64[rs + sext(L)].
  - 0x11 mov: rd = rs.
  - 0x12 mov: rd[11:0] = L; the other bits are kept.
  - 0x13 mov: mem64[rd + sext(L)] = rs.
  - 0x18 add, 0x19 addi (rd += L), 0x1a sub, 0x1b subi (rd -= L). All arithmetic wraps modulo 2^64.
  - 0x1c mul, 0x1d div: see Optional Feature.
- Illegal opcode (including floating-point 0x14–0x17 and 0x1e–0x1f): enter HALTED, with no state change for that instruction.
- HALTED: halt=1; no further register, memory, or PC changes; out_signal=0.
- Reset asserted mid-instruction aborts the instruction. A memory write completes only if its clock edge precedes reset assertion.
- Address arithmetic wraps modulo MEM_SIZE, including accesses that straddle the top of memory.

Optional Feature:
- MULDIV_EN defined:
  - 0x1c mul: rd = low 64 bits of rs*rt (signed).
  - 0x1d div: rd = rs/rt, signed and truncating.
  - Divide by zero gives rd=0 and does not halt.
- MULDIV_EN undefined: 0x1c/0x1d are illegal and halt the core.

Test Plan:
- Reset released with an image whose first word at 0x2000 is priv L=0 (bytes 00 00 00 78) -> halt=1 within 2 cycles; out_signal never asserted; all registers at reset values with r31=524288.
- Program `mov 0x12 r1 L=5; addi r1 L=7; priv L=4 rd=x rs=r1; halt` -> out_signal pulses exactly once with out_data=64'hC; halt=1 afterwards.
- Program containing priv L=3 with in_signal held 0 for 10 cycles, then 1 with in_data=64'hDEADBEEF -> core stalls for those cycles; the register receives DEADBEEF; PC advances only after in_signal=1.
- call/return round trip: r31=0x80000, r5 = subroutine address -> return lands at call+4; mem64[0x7FFF8] holds the return address.
- brgt with rs=-1, rt=1 -> branch not taken; with rs=2, rt=1 -> PC=rd.
- Opcode 0x1d with rt=0 -> with MULDIV_EN, rd=0 and execution continues; without MULDIV_EN, halt=1 and rd is unchanged.
